// File: rtl/alu_issue_ctrl.sv
// Operand-issue stage in front of a combinational ALU: register file, one-cycle
// EXEC handshake, and writeback of the ALU result with a single-cycle strobe.
module alu_issue_ctrl #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 3,
   parameter int unsigned NREGS = 2 ** AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [1:0]       instr_op,
   input  logic [AW-1:0]    instr_rd,
   input  logic [AW-1:0]    instr_rs1,
   input  logic [AW-1:0]    instr_rs2,
   input  logic             ld_en,
   input  logic [AW-1:0]    ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   output logic             wb_valid,
   output logic [AW-1:0]    wb_addr,
   output logic [WIDTH-1:0] wb_data,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [1:0]       alu_sel_q, alu_sel_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic             wb_valid_q, wb_valid_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic [WIDTH-1:0] wb_data_q, wb_data_d;

   // Next-state and datapath; the EXEC writeback is applied after ld_en so it wins a collision.
   always_comb begin
      state_d    = state_q;
      regs_d     = regs_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_sel_d  = alu_sel_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;

      if (ld_en) begin
         regs_d[ld_addr] = ld_data;
      end

      case (state_q)
         IDLE: begin
            if (instr_valid) begin
               alu_a_d   = regs_q[instr_rs1];
               alu_b_d   = regs_q[instr_rs2];
               alu_sel_d = instr_op;
               rd_d      = instr_rd;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            regs_d[rd_q] = alu_result;
            wb_valid_d   = 1'b1;
            wb_addr_d    = rd_q;
            wb_data_d    = alu_result;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_sel_q  <= alu_sel_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign wb_valid    = wb_valid_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;
   assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an adder standing in for the ALU.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  instr_op;
   logic [2:0]  instr_rd, instr_rs1, instr_rs2;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [15:0] alu_a, alu_b;
   logic [1:0]  alu_sel;
   logic [15:0] alu_result;
   logic        wb_valid;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign alu_result = 16'(alu_a + alu_b);

   alu_issue_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_rs1   (instr_rs1),
      .instr_rs2   (instr_rs2),
      .ld_en       (ld_en),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_result  (alu_result),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // One row = inputs held across one rising edge, then outputs expected just after it.
   typedef struct {
      logic        vld;
      logic [1:0]  op;
      logic [2:0]  rd, rs1, rs2;
      logic        ld;
      logic [2:0]  la;
      logic [15:0] ldd;
      logic        dchk;
      logic [2:0]  da;
      logic [15:0] dexp;
      logic        rdy;
      logic [15:0] ea, eb;
      logic [1:0]  es;
      logic        ewv;
      logic [2:0]  ewa;
      logic [15:0] ewd;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(
      input logic vld, input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
      input logic [2:0] rs2, input logic ld, input logic [2:0] la, input logic [15:0] ldd,
      input logic dchk, input logic [2:0] da, input logic [15:0] dexp, input logic rdy,
      input logic [15:0] ea, input logic [15:0] eb, input logic [1:0] es, input logic ewv,
      input logic [2:0] ewa, input logic [15:0] ewd);
      vec_t v;
      v.vld = vld; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.ld = ld; v.la = la; v.ldd = ldd;
      v.dchk = dchk; v.da = da; v.dexp = dexp;
      v.rdy = rdy; v.ea = ea; v.eb = eb; v.es = es;
      v.ewv = ewv; v.ewa = ewa; v.ewd = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      instr_valid = 1'b0; instr_op = 2'd0; instr_rd = 3'd0; instr_rs1 = 3'd0;
      instr_rs2 = 3'd0; ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0;
   endtask

   initial begin
      idle_inputs();
      dbg_addr = 3'd0;
      rst = 1'b1;

      // vld op rd rs1 rs2 | ld la ldd | dchk da dexp | rdy a b sel | wbv wba wbd
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 16'h0005, 1, 1, 16'h0005, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 16'h0002, 1, 2, 16'h0002, 1, 16'h0000, 16'h0000, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 3, 1, 2, 0, 0, 16'h0000, 1, 3, 16'h0000, 0, 16'h0005, 16'h0002, 1, 0, 0, 0));
      // instr_valid held high through EXEC: the pending r4=r3+r3 must wait for writeback
      vecs.push_back(mk(1, 0, 4, 3, 3, 0, 0, 16'h0000, 1, 3, 16'h0007, 1, 16'h0005, 16'h0002, 1, 1, 3, 16'h0007));
      vecs.push_back(mk(1, 0, 4, 3, 3, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0007, 16'h0007, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 5, 4, 1, 0, 0, 16'h0000, 1, 4, 16'h000E, 1, 16'h0007, 16'h0007, 0, 1, 4, 16'h000E));
      vecs.push_back(mk(1, 0, 5, 4, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h000E, 16'h0005, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 5, 16'h0013, 1, 16'h000E, 16'h0005, 0, 1, 5, 16'h0013));
      // wrap-around
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 6, 16'hFFFF, 1, 6, 16'hFFFF, 1, 16'h000E, 16'h0005, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 7, 16'h0001, 1, 7, 16'h0001, 1, 16'h000E, 16'h0005, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2, 6, 6, 7, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'hFFFF, 16'h0001, 2, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 6, 16'h0000, 1, 16'hFFFF, 16'h0001, 2, 1, 6, 16'h0000));
      // same-address collision: writeback beats ld
      vecs.push_back(mk(1, 3, 3, 1, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0005, 16'h0002, 3, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3, 16'hAAAA, 1, 3, 16'h0007, 1, 16'h0005, 16'h0002, 3, 1, 3, 16'h0007));
      // different-address collision: both land
      vecs.push_back(mk(1, 0, 3, 1, 2, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0005, 16'h0002, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 16'h1234, 1, 2, 16'h1234, 1, 16'h0005, 16'h0002, 0, 1, 3, 16'h0007));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 1, 3, 16'h0007, 1, 16'h0005, 16'h0002, 0, 0, 0, 0));

      tick();
      tick();
      chk("rst_ready", -1, 16'(instr_ready), 16'd1);
      chk("rst_a", -1, alu_a, 16'h0);
      chk("rst_b", -1, alu_b, 16'h0);
      chk("rst_sel", -1, 16'(alu_sel), 16'd0);
      chk("rst_wbv", -1, 16'(wb_valid), 16'd0);
      chk("rst_wba", -1, 16'(wb_addr), 16'd0);
      chk("rst_wbd", -1, wb_data, 16'h0);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk("rst_dbg", i, dbg_data, 16'h0);
      end
      rst = 1'b0;

      for (int r = 0; r < vecs.size(); r++) begin
         instr_valid = vecs[r].vld; instr_op = vecs[r].op; instr_rd = vecs[r].rd;
         instr_rs1 = vecs[r].rs1; instr_rs2 = vecs[r].rs2;
         ld_en = vecs[r].ld; ld_addr = vecs[r].la; ld_data = vecs[r].ldd;
         dbg_addr = vecs[r].da;
         tick();
         chk("ready", r, 16'(instr_ready), 16'(vecs[r].rdy));
         chk("alu_a", r, alu_a, vecs[r].ea);
         chk("alu_b", r, alu_b, vecs[r].eb);
         chk("alu_sel", r, 16'(alu_sel), 16'(vecs[r].es));
         chk("wb_valid", r, 16'(wb_valid), 16'(vecs[r].ewv));
         if (vecs[r].ewv) begin
            chk("wb_addr", r, 16'(wb_addr), 16'(vecs[r].ewa));
            chk("wb_data", r, wb_data, vecs[r].ewd);
         end
         if (vecs[r].dchk) chk("dbg", r, dbg_data, vecs[r].dexp);
      end

      // Reset during EXEC aborts the writeback and clears the regfile.
      idle_inputs();
      instr_valid = 1'b1; instr_op = 2'd1; instr_rd = 3'd7; instr_rs1 = 3'd1; instr_rs2 = 3'd2;
      tick();
      chk("abort_accept", 0, 16'(instr_ready), 16'd0);
      chk("abort_a", 0, alu_a, 16'h0005);
      chk("abort_b", 0, alu_b, 16'h1234);
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_wbv", 1, 16'(wb_valid), 16'd0);
      chk("abort_ready", 1, 16'(instr_ready), 16'd1);
      chk("abort_a", 1, alu_a, 16'h0);
      dbg_addr = 3'd7;
      #1;
      chk("abort_r7", 1, dbg_data, 16'h0);
      dbg_addr = 3'd1;
      #1;
      chk("abort_r1", 1, dbg_data, 16'h0);
      tick();
      chk("abort_wbv", 2, 16'(wb_valid), 16'd0);
      chk("abort_ready", 2, 16'(instr_ready), 16'd1);
      dbg_addr = 3'd7;
      #1;
      chk("abort_r7", 2, dbg_data, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Operand-issue stage directly upstream of the 16-bit ALU.
- Holds a small register file and accepts 3-operand instructions over a valid/ready handshake.
- Drives registered A/B/select into the combinational ALU, then captures the ALU result back into the destination register and reports it on a writeback strobe.
- Sits between instruction source (sequencer/testbench) and the ALU.

Parameters:
- WIDTH, 16, datapath width; must match ALU A/B/ALU_Out.
- NREGS, 8, number of register-file entries.
- AW, 3, register address width; NREGS = 2**AW.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  block can accept (high only in IDLE)
- instr_op  in  2  ALU select code, passed through unmodified
- instr_rd  in  AW  destination register
- instr_rs1  in  AW  source for ALU A
- instr_rs2  in  AW  source for ALU B
- ld_en  in  1  external register load strobe
- ld_addr  in  AW  load address
- ld_data  in  WIDTH  load data
- alu_a  out  WIDTH  registered operand A to ALU
- alu_b  out  WIDTH  registered operand B to ALU
- alu_sel  out  2  registered ALU select
- alu_result  in  WIDTH  combinational ALU output
- wb_valid  out  1  one-cycle writeback strobe
- wb_addr  out  AW  register written
- wb_data  out  WIDTH  value written
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (rst high at rising edge): state=IDLE, all regfile entries=0, alu_a=alu_b=0, alu_sel=0, wb_valid=0, wb_addr=0, wb_data=0. rst has priority over every other input.
- FSM has two states, IDLE and EXEC. instr_ready = (state==IDLE), purely from state.
- IDLE:
  - On an edge with instr_valid=1, latch alu_a<=reg[rs1], alu_b<=reg[rs2], alu_sel<=instr_op and internal rd<=instr_rd, then go to EXEC.
  - With instr_valid=0, stay in IDLE and hold alu_* unchanged.
- EXEC (exactly one cycle):
  - ALU result settles combinationally during this cycle.
  - At the closing edge: reg[rd]<=alu_result, wb_valid<=1, wb_addr<=rd, wb_data<=alu_result, then go to IDLE.
- wb_valid is high for exactly one cycle (the IDLE cycle following EXEC) and is 0 otherwise.
- alu_a, alu_b and alu_sel hold their values until the next accept.
- Latency:
  - accept edge T; EXEC in cycle T+1; regfile updated and wb_valid high in cycle T+2.
  - Maximum throughput is one instruction per 2 cycles.
- Back-to-back dependency: an instruction accepted in the wb_valid cycle reads the already-updated register. No bypass logic is needed, and no hazard exists.
- rs1==rs2 is legal: both operands receive the same value. rd may equal rs1 or rs2.
- ld_en:
  - Writes reg[ld_addr]<=ld_data at the edge, in any state.
  - Operand reads at an accept edge see the pre-edge contents; a same-cycle ld_en is not forwarded.
- Same-edge collision: if the EXEC writeback and ld_en target the same address, the writeback wins and the ld is dropped. A collision on different addresses performs both writes.
- wb_valid and wb_* reflect only ALU writebacks, never ld_en.
- dbg_data is a combinational read of the current regfile contents. It shows the new value from the cycle after the write edge.
- Reset asserted during EXEC aborts the instruction:
  - no regfile write and no wb_valid;
  - regfile cleared to 0.
- alu_result is sampled only at the EXEC closing edge; its value in other cycles is ignored.
- All arithmetic is inside the ALU. This block performs no width extension, and results are stored as WIDTH bits unchanged.

Test Plan:
- Bench uses an ALU stub with result = A + B mod 2^16.
- Reset values: hold rst for 2 cycles -> alu_a=alu_b=0, alu_sel=0, wb_valid=0, instr_ready=1, dbg_data=0 for all 8 addresses.
- Single op:
  - Stimulus: ld r1=0x0005, ld r2=0x0002, then issue op=2'h1, rd=3, rs1=1, rs2=2.
  - Response: cycle T+1 has alu_a=0x0005, alu_b=0x0002, alu_sel=1, instr_ready=0.
  - Response: cycle T+2 has wb_valid=1, wb_addr=3, wb_data=0x0007; dbg r3=0x0007.
- Back-to-back dependency:
  - Stimulus: hold instr_valid high; issue rd=4=r3+r3, then rd=5=r4+r1.
  - Response: wb_data 0x000E, then 0x0013; accepts 2 cycles apart.
- Wrap:
  - Stimulus: ld r6=0xFFFF, r7=0x0001, issue rd=6=r6+r7.
  - Response: wb_data=0x0000, r6=0x0000.
- Collision:
  - Stimulus: ld_en to r3 (0xAAAA) on the same edge as the EXEC writeback of rd=3 (value 0x0007).
  - Response: r3=0x0007.
  - Stimulus: repeat with ld to r2.
  - Response: both writes land.
- Reset mid-EXEC:
  - Stimulus: assert rst in the EXEC cycle.
  - Response: no wb_valid, target register reads 0, next cycle in IDLE with instr_ready=1.
